// File: rtl/servo_pkg.sv
// servo_pkg: constants and types shared by the servo PWM generator and decoder
package servo_pkg;
    localparam int DUR_CLOCK_NUM = 1_000_000;
    localparam int DEGREE_MIN    = 25_000;
    localparam int DEGREE_MAX    = 125_000;
    localparam int ANGLE_MAX     = 180;
    localparam int CW            = 21;
    localparam int DW            = 10;
    localparam int AW            = 8;

    typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

    function automatic int step_of(input int dmin, input int dmax);
        return (dmax - dmin) / ANGLE_MAX;
    endfunction

    localparam int STEP = step_of(DEGREE_MIN, DEGREE_MAX);
endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per clock
module serial_divider
    import servo_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [CW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic [CW-1:0] quot_o,
    output logic          busy_o,
    output logic          done_o
);
    logic [CW-1:0] q_q;
    logic [DW-1:0] r_q, den_q;
    logic [4:0]    n_q;
    logic          busy_q, done_q;
    logic [DW:0]   rs;
    logic          ge;

    // shift the next numerator bit into the partial remainder and trial-subtract
    always_comb begin
        rs = {r_q, q_q[CW-1]};
        ge = rs >= {1'b0, den_q};
    end

    // load on start, then retire one quotient bit per clock for CW clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            r_q    <= '0;
            den_q  <= '0;
            n_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= busy_q && n_q == 5'd1;
            if (start_i) begin
                q_q    <= num_i;
                r_q    <= '0;
                den_q  <= den_i;
                n_q    <= 5'(CW);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                q_q    <= {q_q[CW-2:0], ge};
                r_q    <= ge ? DW'(rs - {1'b0, den_q}) : rs[DW-1:0];
                n_q    <= n_q - 5'd1;
                busy_q <= n_q != 5'd1;
            end
        end
    end

    assign quot_o = q_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures a servo PWM pulse train and recovers the 0..180 degree command
module servo_pwm_decoder #(
    parameter int DUR_CLOCK_NUM = servo_pkg::DUR_CLOCK_NUM,
    parameter int DEGREE_MIN    = servo_pkg::DEGREE_MIN,
    parameter int DEGREE_MAX    = servo_pkg::DEGREE_MAX,
    parameter int PERIOD_TOL    = 50_000,
    parameter int TIMEOUT       = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [7:0] angle,
    output logic       angle_valid,
    output logic       frame_err,
    output logic       signal_lost
);
    import servo_pkg::*;

    localparam int            DIV_STEP = step_of(DEGREE_MIN, DEGREE_MAX);
    localparam logic [CW-1:0] P_LO     = CW'(DUR_CLOCK_NUM - PERIOD_TOL);
    localparam logic [CW-1:0] P_HI     = CW'(DUR_CLOCK_NUM + PERIOD_TOL);
    localparam logic [CW-1:0] H_LO     = CW'(DEGREE_MIN - DIV_STEP / 2);
    localparam logic [CW-1:0] H_HI     = CW'(DEGREE_MAX);
    localparam logic [CW-1:0] H_MIN    = CW'(DEGREE_MIN);
    localparam logic [CW-1:0] HALF     = CW'(DIV_STEP / 2);
    localparam logic [CW-1:0] T_OUT    = CW'(TIMEOUT);

    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, high_w_q, period_q;
    state_t        state_q;
    logic          eval_q, bad_q, frame_err_q, angle_valid_q, signal_lost_q;
    logic [AW-1:0] angle_q;
    logic          rise, fall, ok, div_start, div_busy, div_done;
    logic [CW-1:0] num, quot;

    // two-flop synchronizer plus one stage for edge detection; left unreset so a
    // reset while the line is high does not fabricate a rising edge
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[1:0], pwm_in};
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    // time since the last rising edge, saturating so a dead line stays timed out
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= rise ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    end

    assign ok        = period_q >= P_LO && period_q <= P_HI && high_w_q >= H_LO && high_w_q <= H_HI;
    assign div_start = eval_q && ok;
    assign num       = (high_w_q > H_MIN ? high_w_q - H_MIN : '0) + HALF;

    serial_divider u_div (
        .clk     (clk),
        .reset   (reset),
        .start_i (div_start),
        .num_i   (num),
        .den_i   (DW'(DIV_STEP)),
        .quot_o  (quot),
        .busy_o  (div_busy),
        .done_o  (div_done)
    );

    // frame tracking FSM with registered strobes; a rising edge beats the timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEEK;
            high_w_q      <= '0;
            period_q      <= '0;
            eval_q        <= 1'b0;
            bad_q         <= 1'b0;
            frame_err_q   <= 1'b0;
            angle_valid_q <= 1'b0;
            angle_q       <= '0;
            signal_lost_q <= 1'b1;
        end else begin
            eval_q        <= 1'b0;
            bad_q         <= eval_q && !ok;
            frame_err_q   <= bad_q;
            angle_valid_q <= div_done;
            if (div_done) begin
                angle_q       <= quot > CW'(ANGLE_MAX) ? AW'(ANGLE_MAX) : quot[AW-1:0];
                signal_lost_q <= 1'b0;
            end
            if (rise) begin
                state_q <= HIGH;
                if (state_q == LOW) begin
                    period_q <= cnt_q + 1'b1;
                    eval_q   <= 1'b1;
                end
            end else if (cnt_q == T_OUT) begin
                state_q       <= SEEK;
                signal_lost_q <= 1'b1;
            end else if (fall && state_q == HIGH) begin
                high_w_q <= cnt_q + 1'b1;
                state_q  <= LOW;
            end
        end
    end

    // the shortest legal high phase is far longer than one division
    a_div_idle: assert property (@(posedge clk) disable iff (reset) div_start |-> !div_busy);

    assign angle       = angle_q;
    assign angle_valid = angle_valid_q;
    assign frame_err   = frame_err_q;
    assign signal_lost = signal_lost_q;
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: directed frames on scaled timing (STEP=4, MIN=200, MAX=920, frame 1500)
module tb_servo_pwm_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] angle;
    logic       angle_valid, frame_err, signal_lost;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, e0 = 0, lead = 0;
    int av_n = 0, fe_n = 0, av_cyc = 0, fe_cyc = 0, av_ang = 0;
    logic av_sl = 1'b0, av_slb = 1'b0, sl_last = 1'b0;

    servo_pwm_decoder #(
        .DUR_CLOCK_NUM (1500),
        .DEGREE_MIN    (200),
        .DEGREE_MAX    (920),
        .PERIOD_TOL    (75),
        .TIMEOUT       (3000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .angle       (angle),
        .angle_valid (angle_valid),
        .frame_err   (frame_err),
        .signal_lost (signal_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (angle_valid) begin
            av_n++;
            av_cyc = cyc;
            av_ang = int'(angle);
            av_sl  = signal_lost;
            av_slb = sl_last;
        end
        if (frame_err) begin
            fe_n++;
            fe_cyc = cyc;
        end
        sl_last = signal_lost;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // rising edge from SEEK: must produce no strobe
    task automatic open_frame(input string tag);
        int av0, fe0;
        #1 pwm_in = 1'b1;
        e0 = cyc + 1;
        av0 = av_n;
        fe0 = fe_n;
        repeat (30) @(posedge clk);
        #1 lead = 30;
        check({tag, " av_n"}, av_n - av0, 0);
        check({tag, " fe_n"}, fe_n - fe0, 0);
    endtask

    // finish the current frame (high h, period p), close it with a rising edge, check strobes
    task automatic send(input string tag, input int h, input int p, input int exp_ang,
                        input bit exp_av, input bit exp_fe);
        int av0, fe0;
        repeat (h - lead) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (p - h) @(posedge clk);
        #1 pwm_in = 1'b1;
        e0 = cyc + 1;
        av0 = av_n;
        fe0 = fe_n;
        repeat (30) @(posedge clk);
        #1 lead = 30;
        check({tag, " av_n"}, av_n - av0, int'(exp_av));
        check({tag, " fe_n"}, fe_n - fe0, int'(exp_fe));
        check({tag, " angle"}, int'(angle), exp_ang);
        if (exp_av) begin
            check({tag, " av_ang"}, av_ang, exp_ang);
            check({tag, " av_lat"}, av_cyc - e0, 25);
        end
        if (exp_fe) check({tag, " fe_lat"}, fe_cyc - e0, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst angle", int'(angle), 0);
        check("rst av", int'(angle_valid), 0);
        check("rst fe", int'(frame_err), 0);
        check("rst lost", int'(signal_lost), 1);
        repeat (5) @(posedge clk);

        open_frame("first");
        send("g90a", 560, 1500, 90, 1, 0);
        check("g90a lost", int'(signal_lost), 0);
        send("g90b", 560, 1500, 90, 1, 0);
        send("h200", 200, 1500, 0, 1, 0);
        send("h920", 920, 1500, 180, 1, 0);
        send("h197", 197, 1500, 180, 0, 1);
        send("h921", 921, 1500, 180, 0, 1);
        send("h198", 198, 1500, 0, 1, 0);
        send("h201", 201, 1500, 0, 1, 0);
        send("h202", 202, 1500, 1, 1, 0);
        send("p1200", 560, 1200, 1, 0, 1);
        send("h100", 100, 1500, 1, 0, 1);
        send("p1425", 560, 1425, 90, 1, 0);
        send("p1424", 560, 1424, 90, 0, 1);
        send("p1575", 600, 1575, 100, 1, 0);
        send("p1576", 600, 1576, 100, 0, 1);
        send("tie", 560, 3001, 100, 0, 1);
        check("tie lost", int'(signal_lost), 0);
        send("after_tie", 560, 1500, 90, 1, 0);

        for (int i = 0; i < 6; i++) begin
            int a;
            a = int'($urandom_range(0, 180));
            send($sformatf("rnd%0d", i), 4 * a + 200, 1500, a, 1, 0);
        end

        repeat (560 - lead) @(posedge clk);
        #1 pwm_in = 1'b0;
        while (cyc < e0 + 3002) begin
            @(posedge clk);
            #1;
        end
        check("pre_timeout lost", int'(signal_lost), 0);
        @(posedge clk);
        #1 check("timeout lost", int'(signal_lost), 1);
        repeat (20) @(posedge clk);

        open_frame("relock_seek");
        check("relock_seek lost", int'(signal_lost), 1);
        send("relock", 560, 1500, 90, 1, 0);
        check("relock sl_at_av", int'(av_sl), 0);
        check("relock sl_before", int'(av_slb), 1);

        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        lead = 81;
        check("midrst angle", int'(angle), 0);
        check("midrst av", int'(angle_valid), 0);
        check("midrst fe", int'(frame_err), 0);
        check("midrst lost", int'(signal_lost), 1);
        send("post_rst1", 560, 1500, 0, 0, 0);
        send("post_rst2", 600, 1500, 100, 1, 0);
        check("post_rst2 lost", int'(signal_lost), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
